max_pool_2x2_stream: RTL and testbench
======================================

// Module: max_pool_2x2_stream
// PURPOSE
//  2x2 / stride-2 max-pooling stage directly downstream of the convolution
//  datapath. Consumes its raster-ordered pixel stream (pixel_OUT, one pixel per
//  valid_in beat) and emits one pooled pixel per 2x2 window. Raster order is
//  preserved. A half-row line buffer keeps even-row pair maxima until the
//  matching odd row arrives. pool_done flags frame completion to the top FSM.
// PARAMETERS
//  DATA_WIDTH  8   pixel width, unsigned
//  IMG_W       26  input frame width in pixels (>=2)
//  IMG_H       26  input frame height in pixels (>=2)
// PORTS
//  clk        in   1           rising-edge clock
//  reset      in   1           synchronous, active-low reset
//  valid_in   in   1           pixel_IN valid this cycle
//  pixel_IN   in   DATA_WIDTH  input pixel, raster order
//  valid_out  out  1           pixel_OUT valid, one-cycle pulse per output
//  pixel_OUT  out  DATA_WIDTH  pooled pixel (max of 2x2 window)
//  pool_done  out  1           one-cycle pulse: last pooled pixel of frame emitted
// BEHAVIOUR
//  - reset==0 at posedge: col=0, row=0, state=S_EVEN, pair register=0,
//    valid_out=0, pixel_OUT=0, pool_done=0. Line-buffer contents need no clear.
//    Reset mid-frame discards the partial frame; the next valid_in is pixel (0,0).
//  - No back-pressure. valid_in=0 freezes all counters, state and buffers.
//    Gaps of any length between beats are legal.
//  - Counters: col 0..IMG_W-1, row 0..IMG_H-1. Advance on each valid_in beat.
//    col wraps to 0 and row increments at end of line.
//  - Pooled size: OW=IMG_W/2, OH=IMG_H/2 (floor). An odd trailing column
//    (col==IMG_W-1, IMG_W odd) is accepted and ignored.
//  - FSM, per row, updated on the last beat of each row:
//    S_EVEN : even row. col even -> pair_reg<=px. col odd -> lb[col/2]<=max(pair_reg,px).
//             End of row -> S_ODD.
//    S_ODD  : odd row. col even -> pair_reg<=px. col odd ->
//             pixel_OUT<=max(lb[col/2],pair_reg,px), valid_out<=1 next cycle.
//             End of row -> S_EVEN. If the next row is IMG_H-1 and IMG_H is odd,
//             go to S_SKIP instead. On the last row of the frame, go to S_EVEN
//             and set row=0.
//    S_SKIP : trailing odd row. Pixels accepted, no output.
//             End of row -> S_EVEN, row=0.
//  - Latency: valid_out is asserted exactly 1 cycle after the beat carrying the
//    bottom-right pixel of a window. pixel_OUT holds its value until the next output.
//  - pool_done is asserted in the same cycle as valid_out for pooled pixel
//    (OH-1,OW-1). Counters are already at frame start, so a new frame may begin
//    on the very next cycle.
//  - Comparison is unsigned, DATA_WIDTH bits, no saturation or rounding. Ties
//    return the equal value.
//  - Line buffer: OW entries x DATA_WIDTH, single write port and single read
//    port. A read of lb[k] in S_ODD always follows its write in S_EVEN.
// TESTING
//  1 IMG_W=4,IMG_H=4, pixels 0..15 back-to-back -> valid_out pulses with 5,7,13,15;
//    pool_done on the cycle that outputs 15.
//  2 Same frame, valid_in toggling 1-0-0-1 -> identical outputs and order;
//    no valid_out during gaps that do not complete a window.
//  3 IMG_W=5,IMG_H=5, pixels 0..24 -> outputs 6,8,16,18; pool_done with 18;
//    row 4 and col 4 produce nothing.
//  4 Window {255,0,0,0} and window {7,7,7,7} -> 255 and 7.
//  5 Reset low for 1 cycle after pixel 9 of frame 1, then full frame 0..15 ->
//    only 5,7,13,15 are emitted after reset.
//  6 Two 4x4 frames back-to-back with no gap -> 8 outputs and 2 pool_done pulses;
//    second frame's results are independent of the first.

Source files
------------

// File: rtl/max_pool_2x2_stream.sv
// 2x2 / stride-2 max-pooling over a raster pixel stream.
// Even-row pair maxima wait in a half-row line buffer until the odd row closes each window.
module max_pool_2x2_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 26,
  parameter int IMG_H      = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pixel_IN,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] pixel_OUT,
  output logic                  pool_done
);

  localparam int OW = IMG_W / 2;
  localparam int OH = IMG_H / 2;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_LASTW = CW'(2 * OW - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_LASTW = RW'(2 * OH - 1);
  localparam logic          ODD_W     = (IMG_W % 2) == 1;
  localparam logic          ODD_H     = (IMG_H % 2) == 1;

  typedef enum logic [1:0] {S_EVEN, S_ODD, S_SKIP} state_t;

  function automatic logic [DATA_WIDTH-1:0] umax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [DATA_WIDTH-1:0]   pair_q, pair_d;
  logic                    vout_q, vout_d;
  logic [DATA_WIDTH-1:0]   pout_q, pout_d;
  logic                    done_q, done_d;

  logic [DATA_WIDTH-1:0]   lb_q [OW];
  logic [AW-1:0]           lb_addr;
  logic                    lb_we;
  logic [DATA_WIDTH-1:0]   pair_max;
  logic [DATA_WIDTH-1:0]   win_max;
  logic                    in_win;

  assign lb_addr  = AW'(col_q >> 1);
  assign pair_max = umax(pair_q, pixel_IN);
  assign win_max  = umax(lb_q[lb_addr], pair_max);
  // An odd frame width leaves a trailing column that belongs to no window.
  assign in_win   = !(ODD_W && (col_q == COL_LAST));

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pair_d  = pair_q;
    pout_d  = pout_q;
    vout_d  = 1'b0;
    done_d  = 1'b0;
    lb_we   = 1'b0;
    if (valid_in) begin
      if (in_win) begin
        unique case (state_q)
          S_EVEN: begin
            if (!col_q[0]) pair_d = pixel_IN;
            else           lb_we  = 1'b1;
          end
          S_ODD: begin
            if (!col_q[0]) begin
              pair_d = pixel_IN;
            end else begin
              vout_d = 1'b1;
              pout_d = win_max;
              done_d = (row_q == ROW_LASTW) && (col_q == COL_LASTW);
            end
          end
          default: ;
        endcase
      end
      if (col_q == COL_LAST) begin
        col_d = '0;
        unique case (state_q)
          S_EVEN: begin
            state_d = S_ODD;
            row_d   = row_q + 1'b1;
          end
          S_ODD: begin
            if (row_q == ROW_LAST) begin
              state_d = S_EVEN;
              row_d   = '0;
            end else if (ODD_H && ((row_q + 1'b1) == ROW_LAST)) begin
              state_d = S_SKIP;
              row_d   = row_q + 1'b1;
            end else begin
              state_d = S_EVEN;
              row_d   = row_q + 1'b1;
            end
          end
          default: begin
            state_d = S_EVEN;
            row_d   = '0;
          end
        endcase
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_EVEN;
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      vout_q  <= 1'b0;
      pout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      vout_q  <= vout_d;
      pout_q  <= pout_d;
      done_q  <= done_d;
    end
  end

  // Line buffer carries no reset: every entry is written on an even row before it is read.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[lb_addr] <= pair_max;
  end

  assign valid_out = vout_q;
  assign pixel_OUT = pout_q;
  assign pool_done = done_q;

endmodule

// File: tb/tb_max_pool_2x2_stream.sv
// Bench for max_pool_2x2_stream: a 4x4 instance (A) and a 5x5 instance (B)
// checked against a frame-array reference model plus fixed vector tables.
module tb_max_pool_2x2_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_vin = 1'b0, b_vin = 1'b0;
  logic [7:0] a_pin = '0, b_pin = '0;
  logic       a_vout, b_vout, a_done, b_done;
  logic [7:0] a_pout, b_pout;

  always #5 clk = ~clk;

  max_pool_2x2_stream #(.DATA_WIDTH(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .reset(rst_n), .valid_in(a_vin), .pixel_IN(a_pin),
    .valid_out(a_vout), .pixel_OUT(a_pout), .pool_done(a_done));

  max_pool_2x2_stream #(.DATA_WIDTH(8), .IMG_W(5), .IMG_H(5)) dut_b (
    .clk(clk), .reset(rst_n), .valid_in(b_vin), .pixel_IN(b_pin),
    .valid_out(b_vout), .pixel_OUT(b_pout), .pool_done(b_done));

  int total = 0;
  int bad   = 0;

  int m_frame [2][5][5];
  int m_idx   [2];
  int last_o  [2];
  int outs_a[$];
  int outs_b[$];
  int done_cnt [2];

  typedef struct {
    logic       v;
    logic [7:0] px;
    logic       ev;
    logic [7:0] ex;
    logic       ed;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_log();
    outs_a.delete();
    outs_b.delete();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  endtask

  // Drive one cycle on the selected instance and check its outputs one tick after the edge.
  task automatic drive_chk(input int sel, input logic v, input logic [7:0] px,
                           input logic ev, input logic [7:0] ex, input logic ed);
    logic       vo, dn;
    logic [7:0] po;
    @(negedge clk);
    a_vin = (sel == 0) && v;
    b_vin = (sel == 1) && v;
    if (sel == 0) a_pin = px; else b_pin = px;
    @(posedge clk);
    #1;
    vo = (sel == 0) ? a_vout : b_vout;
    po = (sel == 0) ? a_pout : b_pout;
    dn = (sel == 0) ? a_done : b_done;
    chk($sformatf("valid_out[%0d]", sel), 32'(vo), 32'(ev));
    chk($sformatf("pool_done[%0d]", sel), 32'(dn), 32'(ed));
    if (ev) begin
      chk($sformatf("pixel_OUT[%0d]", sel), 32'(po), 32'(ex));
      last_o[sel] = ex;
    end else begin
      chk($sformatf("pixel_OUT hold[%0d]", sel), 32'(po), 32'(last_o[sel]));
    end
    if (vo) begin
      if (sel == 0) outs_a.push_back(int'(po)); else outs_b.push_back(int'(po));
    end
    if (dn) done_cnt[sel]++;
  endtask

  // Reference: place the pixel in a frame array; a window completes at any odd (row, col).
  task automatic step(input int sel, input logic v, input logic [7:0] px);
    int w, r, c, ex;
    logic ev, ed;
    w  = (sel == 0) ? 4 : 5;
    ev = 1'b0;
    ed = 1'b0;
    ex = 0;
    if (v) begin
      r = m_idx[sel] / w;
      c = m_idx[sel] % w;
      m_frame[sel][r][c] = int'(px);
      if ((r % 2 == 1) && (c % 2 == 1)) begin
        ev = 1'b1;
        ex = max2(max2(m_frame[sel][r-1][c-1], m_frame[sel][r-1][c]),
                  max2(m_frame[sel][r][c-1], m_frame[sel][r][c]));
        ed = (r == 2 * (w / 2) - 1) && (c == 2 * (w / 2) - 1);
      end
      m_idx[sel] = (m_idx[sel] + 1) % (w * w);
    end
    drive_chk(sel, v, px, ev, 8'(ex), ed);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    a_vin = 1'b0;
    b_vin = 1'b0;
    @(posedge clk);
    #1;
    chk("reset valid_out A", 32'(a_vout), 0);
    chk("reset pixel_OUT A", 32'(a_pout), 0);
    chk("reset pool_done A", 32'(a_done), 0);
    chk("reset valid_out B", 32'(b_vout), 0);
    chk("reset pixel_OUT B", 32'(b_pout), 0);
    chk("reset pool_done B", 32'(b_done), 0);
    rst_n = 1'b1;
    m_idx[0] = 0;
    m_idx[1] = 0;
    last_o[0] = 0;
    last_o[1] = 0;
  endtask

  task automatic chk_outs(input string nm, input int sel, input int n, input int e0,
                          input int e1, input int e2, input int e3);
    int e[4];
    int q[$];
    e = '{e0, e1, e2, e3};
    q = (sel == 0) ? outs_a : outs_b;
    chk({nm, " count"}, 32'(q.size()), 32'(n));
    for (int i = 0; i < n && i < 4; i++)
      chk($sformatf("%s out%0d", nm, i), (i < q.size()) ? 32'(q[i]) : 32'hFFFF_FFFF, 32'(e[i]));
  endtask

  vec_t tv [16];
  int   tw [16];

  initial begin
    for (int i = 0; i < 16; i++) tv[i] = '{1'b1, 8'(i), 1'b0, 8'd0, 1'b0};
    tv[5].ev  = 1'b1; tv[5].ex  = 8'd5;
    tv[7].ev  = 1'b1; tv[7].ex  = 8'd7;
    tv[13].ev = 1'b1; tv[13].ex = 8'd13;
    tv[15].ev = 1'b1; tv[15].ex = 8'd15; tv[15].ed = 1'b1;
    tw = '{255, 0, 7, 7, 0, 0, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0};

    do_reset();

    // 4x4 ramp back to back, fixed vectors.
    clear_log();
    for (int i = 0; i < 16; i++)
      drive_chk(0, tv[i].v, tv[i].px, tv[i].ev, tv[i].ex, tv[i].ed);
    drive_chk(0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    chk_outs("ramp4", 0, 4, 5, 7, 13, 15);
    chk("ramp4 done count", 32'(done_cnt[0]), 1);

    // Same ramp with valid toggling 1-0-0-1.
    clear_log();
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b1, 8'(i));
      if (i != 15) begin
        step(0, 1'b0, 8'd0);
        step(0, 1'b0, 8'd0);
      end
    end
    step(0, 1'b0, 8'd0);
    chk_outs("gapped4", 0, 4, 5, 7, 13, 15);
    chk("gapped4 done count", 32'(done_cnt[0]), 1);

    // 5x5 ramp: trailing row and column are dropped.
    clear_log();
    for (int i = 0; i < 25; i++) step(1, 1'b1, 8'(i));
    step(1, 1'b0, 8'd0);
    chk_outs("ramp5", 1, 4, 6, 8, 16, 18);
    chk("ramp5 done count", 32'(done_cnt[1]), 1);

    // Extreme and tied windows.
    clear_log();
    for (int i = 0; i < 16; i++) step(0, 1'b1, 8'(tw[i]));
    step(0, 1'b0, 8'd0);
    chk_outs("extremes", 0, 4, 255, 7, 0, 0);

    // Reset mid-frame, then a clean frame.
    for (int i = 0; i < 10; i++) step(0, 1'b1, 8'(i));
    do_reset();
    clear_log();
    for (int i = 0; i < 16; i++) step(0, 1'b1, 8'(i));
    step(0, 1'b0, 8'd0);
    chk_outs("after reset", 0, 4, 5, 7, 13, 15);

    // Two random frames with no gap between them.
    clear_log();
    for (int i = 0; i < 32; i++) step(0, 1'b1, 8'($urandom_range(0, 255)));
    step(0, 1'b0, 8'd0);
    chk("b2b out count", 32'(outs_a.size()), 8);
    chk("b2b done count", 32'(done_cnt[0]), 2);

    // Random frames with random gaps on both instances.
    clear_log();
    for (int f = 0; f < 8; f++) begin
      int sel, n;
      sel = f % 2;
      n = (sel == 0) ? 16 : 25;
      for (int i = 0; i < n; i++) begin
        int g;
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) step(sel, 1'b0, 8'd0);
        step(sel, 1'b1, 8'($urandom_range(0, 255)));
      end
    end
    step(0, 1'b0, 8'd0);
    chk("random done count A", 32'(done_cnt[0]), 4);
    chk("random done count B", 32'(done_cnt[1]), 4);
    chk("random out count A", 32'(outs_a.size()), 16);
    chk("random out count B", 32'(outs_b.size()), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
